// File: rtl/hex_frame_pkg.sv
// Shared types and ASCII constants for the hex entry front end.
package hex_frame_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE,
    S_ERROR
  } frame_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BADCHAR  = 2'd1,
    ERR_OVERFLOW = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_code_e;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_UC_A  = 8'h41;
  localparam logic [7:0] ASCII_UC_F  = 8'h46;
  localparam logic [7:0] ASCII_LC_A  = 8'h61;
  localparam logic [7:0] ASCII_LC_F  = 8'h66;

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational ASCII byte classifier: hex digit, CR terminator, LF, and nibble value.
import hex_frame_pkg::*;

module ascii_hex_decode (
  input  logic [7:0] ascii,
  output logic       is_hex,
  output logic       is_term,
  output logic       is_lf,
  output logic [3:0] nibble
);

  always_comb begin
    is_hex  = 1'b0;
    nibble  = '0;
    is_term = (ascii == ASCII_CR);
    is_lf   = (ascii == ASCII_LF);
    if (ascii >= ASCII_0 && ascii <= ASCII_9) begin
      is_hex = 1'b1;
      nibble = ascii[3:0];
    end else if ((ascii >= ASCII_UC_A && ascii <= ASCII_UC_F) ||
                 (ascii >= ASCII_LC_A && ascii <= ASCII_LC_F)) begin
      // Letters A-F/a-f have low nibble 1..6, so the digit value is that plus 9.
      is_hex = 1'b1;
      nibble = ascii[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/hex_frame_ctrl.sv
// Hex entry framing controller: decodes UART bytes into nibbles and frames entries.
// Optional echo path enabled by defining HEX_FRAME_ECHO_EN.
import hex_frame_pkg::*;

module hex_frame_ctrl #(
  parameter int MAX_DIGITS  = 6,
  parameter int TIMEOUT_CYC = 6_000_000
) (
  input  logic       clk_60mhz,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_strobe,
  input  logic       frame_ack,
  output logic [3:0] nib_data,
  output logic       nib_valid,
  output logic       char_check,
  output logic       frame_done,
  output logic [2:0] frame_len,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       rx_drop,
`ifdef HEX_FRAME_ECHO_EN
  output logic [7:0] tx_byte,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       echo_ovf,
`endif
  output logic       busy
);

  localparam int         TW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0] MAXD  = 3'(MAX_DIGITS);

  frame_state_e  state;
  logic [2:0]    count;
  logic [TW-1:0] tcnt;

  logic       is_hex, is_term, is_lf;
  logic [3:0] nibble;
  logic       stb;

  ascii_hex_decode u_decode (
    .ascii   (rx_byte),
    .is_hex  (is_hex),
    .is_term (is_term),
    .is_lf   (is_lf),
    .nibble  (nibble)
  );

  // LF is invisible to the framer, including the timeout.
  assign stb = rx_strobe && !is_lf;

  always_ff @(posedge clk_60mhz) begin
    if (rst) begin
      state      <= S_IDLE;
      count      <= '0;
      tcnt       <= '0;
      nib_data   <= '0;
      nib_valid  <= 1'b0;
      char_check <= 1'b0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
      rx_drop    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      nib_valid  <= 1'b0;
      char_check <= 1'b0;
      if (stb) tcnt <= '0;
      unique case (state)
        S_IDLE: begin
          if (stb) begin
            if (is_hex) begin
              nib_data  <= nibble;
              nib_valid <= 1'b1;
              count     <= 3'd1;
              state     <= S_COLLECT;
              busy      <= 1'b1;
            end else if (!is_term) begin
              char_check <= 1'b1;
              frame_err  <= 1'b1;
              err_code   <= ERR_BADCHAR;
              state      <= S_ERROR;
              busy       <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (stb) begin
            if (is_hex && count < MAXD) begin
              nib_data  <= nibble;
              nib_valid <= 1'b1;
              count     <= count + 3'd1;
            end else if (is_hex) begin
              char_check <= 1'b1;
              frame_err  <= 1'b1;
              err_code   <= ERR_OVERFLOW;
              state      <= S_ERROR;
            end else if (is_term) begin
              char_check <= 1'b1;
              frame_done <= 1'b1;
              frame_len  <= count;
              state      <= S_DONE;
            end else begin
              char_check <= 1'b1;
              frame_err  <= 1'b1;
              err_code   <= ERR_BADCHAR;
              state      <= S_ERROR;
            end
          end else if (tcnt == TLAST) begin
            char_check <= 1'b1;
            frame_err  <= 1'b1;
            err_code   <= ERR_TIMEOUT;
            state      <= S_ERROR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DONE: begin
          // Ack takes priority; a byte arriving with it is simply discarded.
          if (frame_ack) begin
            frame_done <= 1'b0;
            rx_drop    <= 1'b0;
            state      <= S_IDLE;
            busy       <= 1'b0;
          end else if (stb) begin
            rx_drop <= 1'b1;
          end
        end
        S_ERROR: begin
          if (stb && is_term) begin
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef HEX_FRAME_ECHO_EN
  logic [7:0] echo_data;
  logic       echo_full;
  logic       echo_load;
  logic       echo_drain;

  assign echo_load  = stb && ((state == S_IDLE && (is_hex || is_term)) ||
                              (state == S_COLLECT && (is_term || (is_hex && count < MAXD))));
  assign echo_drain = echo_full && !tx_busy;

  // tx_byte is captured at drain so a same-cycle reload cannot alter the byte in flight.
  always_ff @(posedge clk_60mhz) begin
    if (rst) begin
      echo_data <= '0;
      echo_full <= 1'b0;
      echo_ovf  <= 1'b0;
      tx_byte   <= '0;
      tx_start  <= 1'b0;
    end else begin
      tx_start <= echo_drain;
      if (echo_drain) tx_byte <= echo_data;
      if (echo_load) begin
        echo_data <= rx_byte;
        echo_full <= 1'b1;
        if (echo_full && !echo_drain) echo_ovf <= 1'b1;
      end else if (echo_drain) begin
        echo_full <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hex_frame_ctrl.sv
// Self-checking bench for hex_frame_ctrl: directed scenarios plus randomized traffic against a byte-level model.
module tb_hex_frame_ctrl;

  logic       clk_60mhz = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       rx_strobe = 1'b0;
  logic       frame_ack = 1'b0;
  logic [3:0] nib_data;
  logic       nib_valid, char_check, frame_done, frame_err, rx_drop, busy;
  logic [2:0] frame_len;
  logic [1:0] err_code;
`ifdef HEX_FRAME_ECHO_EN
  logic [7:0] tx_byte;
  logic       tx_start, echo_ovf;
  logic       tx_busy = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] mon_nibs[$];
  int         mon_cc;

  always #5 clk_60mhz = ~clk_60mhz;

  hex_frame_ctrl #(.MAX_DIGITS(6), .TIMEOUT_CYC(100)) dut (
    .clk_60mhz  (clk_60mhz),
    .rst        (rst),
    .rx_byte    (rx_byte),
    .rx_strobe  (rx_strobe),
    .frame_ack  (frame_ack),
    .nib_data   (nib_data),
    .nib_valid  (nib_valid),
    .char_check (char_check),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .rx_drop    (rx_drop),
`ifdef HEX_FRAME_ECHO_EN
    .tx_byte    (tx_byte),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .echo_ovf   (echo_ovf),
`endif
    .busy       (busy)
  );

  always @(negedge clk_60mhz) begin
    if (nib_valid) mon_nibs.push_back(nib_data);
    if (char_check) mon_cc++;
    if (nib_valid || char_check) begin
      checks++;
      if (nib_valid && char_check) begin
        errors++;
        $display("FAIL pulse_exclusive nib_valid=%0b char_check=%0b required not both", nib_valid, char_check);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_60mhz);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte   = b;
    rx_strobe = 1'b1;
    tick(1);
    rx_strobe = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(8'(s[i]));
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    tick(1);
    frame_ack = 1'b0;
  endtask

  task automatic clear_mon();
    mon_nibs.delete();
    mon_cc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    checks++;
    if ({nib_data, nib_valid, char_check, frame_done, frame_len, frame_err, err_code, rx_drop, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got nib=%h nv=%b cc=%b done=%b len=%0d err=%b code=%0d drop=%b busy=%b required all 0",
               nib_data, nib_valid, char_check, frame_done, frame_len, frame_err, err_code, rx_drop, busy);
    end
  endtask

  task automatic test_frame();
    logic [3:0] exp[6] = '{4'h1, 4'hA, 4'h2, 4'hB, 4'h3, 4'hC};
    clear_mon();
    send_str("1A2b3C");
    send(8'h0D);
    tick(1);
    checks++;
    if (mon_nibs.size() != 6) begin
      errors++;
      $display("FAIL frame_nib_count got %0d required 6", mon_nibs.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (mon_nibs[i] !== exp[i]) begin
          errors++;
          $display("FAIL frame_nib[%0d] got %h required %h", i, mon_nibs[i], exp[i]);
        end
      end
    end
    checks++;
    if (mon_cc != 1 || frame_done !== 1'b1 || frame_len !== 3'd6 || busy !== 1'b1) begin
      errors++;
      $display("FAIL frame_status got cc=%0d done=%b len=%0d busy=%b required 1 1 6 1", mon_cc, frame_done, frame_len, busy);
    end
    do_ack();
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || frame_len !== 3'd6) begin
      errors++;
      $display("FAIL frame_after_ack got done=%b busy=%b len=%0d required 0 0 6", frame_done, busy, frame_len);
    end
  endtask

  task automatic test_overflow();
    clear_mon();
    send_str("1234567");
    tick(1);
    checks++;
    if (mon_nibs.size() != 6 || mon_cc != 1 || frame_err !== 1'b1 || err_code !== 2'd2) begin
      errors++;
      $display("FAIL overflow got nibs=%0d cc=%0d err=%b code=%0d required 6 1 1 2", mon_nibs.size(), mon_cc, frame_err, err_code);
    end
    send_str("0");
    checks++;
    if (frame_err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL overflow_hold got err=%b code=%0d busy=%b required 1 2 1", frame_err, err_code, busy);
    end
    send(8'h0D);
    checks++;
    if (frame_err !== 1'b0 || err_code !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear got err=%b code=%0d busy=%b required 0 0 0", frame_err, err_code, busy);
    end
  endtask

  task automatic test_badchar();
    clear_mon();
    send_str("4G");
    tick(1);
    checks++;
    if (mon_nibs.size() != 1 || mon_cc != 1 || err_code !== 2'd1 || frame_err !== 1'b1) begin
      errors++;
      $display("FAIL badchar got nibs=%0d cc=%0d code=%0d err=%b required 1 1 1 1", mon_nibs.size(), mon_cc, err_code, frame_err);
    end else begin
      checks++;
      if (mon_nibs[0] !== 4'h4) begin
        errors++;
        $display("FAIL badchar_nib got %h required 4", mon_nibs[0]);
      end
    end
    send(8'h0A);
    send_str("5z");
    tick(1);
    checks++;
    if (mon_nibs.size() != 1 || mon_cc != 1 || err_code !== 2'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL badchar_ignore got nibs=%0d cc=%0d code=%0d busy=%b required 1 1 1 1", mon_nibs.size(), mon_cc, err_code, busy);
    end
    send(8'h0D);
    send(8'h0A);
    send(8'h0D);
    tick(1);
    checks++;
    if (frame_err !== 1'b0 || err_code !== 2'd0 || busy !== 1'b0 || mon_cc != 1 || mon_nibs.size() != 1) begin
      errors++;
      $display("FAIL badchar_clear got err=%b code=%0d busy=%b cc=%0d required 0 0 0 1", frame_err, err_code, busy, mon_cc);
    end
  endtask

  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      int n = 0;
      clear_mon();
      rx_byte   = 8'h37;
      rx_strobe = 1'b1;
      tick(1);
      rx_strobe = 1'b0;
      while (n < 200) begin
        if (pass == 1 && n == 50) begin
          rx_byte   = 8'h0A;
          rx_strobe = 1'b1;
        end
        tick(1);
        rx_strobe = 1'b0;
        n++;
        if (frame_err) break;
      end
      checks++;
      if (n != 100 || char_check !== 1'b1 || err_code !== 2'd3) begin
        errors++;
        $display("FAIL timeout_pass%0d got cycles=%0d cc=%b code=%0d required 100 1 3", pass, n, char_check, err_code);
      end
      send(8'h0D);
      checks++;
      if (frame_err !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL timeout_clear got err=%b busy=%b required 0 0", frame_err, busy);
      end
    end
  endtask

  task automatic test_done_drop();
    clear_mon();
    send_str("5");
    send(8'h0D);
    send_str("5");
    tick(1);
    checks++;
    if (rx_drop !== 1'b1 || frame_done !== 1'b1 || frame_len !== 3'd1 || mon_nibs.size() != 1) begin
      errors++;
      $display("FAIL drop got drop=%b done=%b len=%0d nibs=%0d required 1 1 1 1", rx_drop, frame_done, frame_len, mon_nibs.size());
    end
    rx_byte   = 8'h38;
    rx_strobe = 1'b1;
    frame_ack = 1'b1;
    tick(1);
    rx_strobe = 1'b0;
    frame_ack = 1'b0;
    tick(1);
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || mon_nibs.size() != 1) begin
      errors++;
      $display("FAIL ack_with_strobe got busy=%b done=%b nibs=%0d required 0 0 1", busy, frame_done, mon_nibs.size());
    end
    send_str("9");
    send(8'h0D);
    tick(1);
    checks++;
    if (mon_nibs.size() != 2 || frame_done !== 1'b1 || frame_len !== 3'd1) begin
      errors++;
      $display("FAIL after_drop_frame got nibs=%0d done=%b len=%0d required 2 1 1", mon_nibs.size(), frame_done, frame_len);
    end
    do_ack();
  endtask

  task automatic test_rst_mid();
    send_str("123");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if ({nib_data, nib_valid, char_check, frame_done, frame_len, frame_err, err_code, rx_drop, busy} !== '0) begin
      errors++;
      $display("FAIL rst_mid got nv=%b cc=%b done=%b len=%0d err=%b busy=%b required all 0",
               nib_valid, char_check, frame_done, frame_len, frame_err, busy);
    end
    clear_mon();
    send_str("9");
    send(8'h0D);
    tick(1);
    checks++;
    if (frame_done !== 1'b1 || frame_len !== 3'd1 || mon_cc != 1 || mon_nibs.size() != 1) begin
      errors++;
      $display("FAIL rst_mid_frame got done=%b len=%0d cc=%0d nibs=%0d required 1 1 1 1", frame_done, frame_len, mon_cc, mon_nibs.size());
    end
    do_ack();
  endtask

  // Byte-level reference: tracks the frame phase and digits received, predicts each cycle's outputs.
  task automatic test_back_to_back();
    string      hx = "0123456789ABCDEFabcdef";
    int         mode = 0;   // 0 idle, 1 collecting, 2 complete, 3 aborted
    int         digits = 0;
    int         quiet = 0;
    logic       e_nv, e_cc, e_done, e_err, e_drop;
    logic [3:0] e_nib;
    logic [2:0] e_len;
    logic [1:0] e_code;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    e_done = 0; e_err = 0; e_drop = 0; e_len = 0; e_code = 0; e_nib = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      logic       stb, ack, h, t, lf;
      logic [7:0] b;
      int         r;
      stb = ($urandom_range(0, 99) < 80) || quiet >= 60;
      ack = ($urandom_range(0, 99) < 20);
      r   = $urandom_range(0, 99);
      if (r < 55) b = 8'(hx[$urandom_range(0, 21)]);
      else if (r < 70) b = 8'h0D;
      else if (r < 78 && quiet < 60) b = 8'h0A;
      else begin
        b = 8'($urandom);
        if ((b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f") || b == 8'h0D || b == 8'h0A)
          b = "G";
      end
      h  = (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
      t  = (b == 8'h0D);
      lf = (b == 8'h0A);
      if (stb && !lf) quiet = 0; else quiet++;
      e_nv = 0;
      e_cc = 0;
      if (stb && !lf && (mode == 0 || mode == 1)) begin
        if (h && digits < 6) begin
          e_nv   = 1;
          e_nib  = (b <= "9") ? 4'(b - "0") : (b <= "F") ? 4'(b - "A" + 10) : 4'(b - "a" + 10);
          digits = (mode == 0) ? 1 : digits + 1;
          mode   = 1;
        end else if (t && mode == 1) begin
          e_cc = 1; e_done = 1; e_len = 3'(digits); mode = 2;
        end else if (!t) begin
          e_cc = 1; e_err = 1; e_code = h ? 2'd2 : 2'd1; mode = 3;
        end
      end else if (mode == 2) begin
        if (ack) begin
          e_done = 0; e_drop = 0; mode = 0;
        end else if (stb && !lf) e_drop = 1;
      end else if (mode == 3 && stb && t) begin
        e_err = 0; e_code = 0; mode = 0;
      end
      if (mode == 0) digits = 0;
      rx_byte   = b;
      rx_strobe = stb;
      frame_ack = ack;
      tick(1);
      checks++;
      if (nib_valid !== e_nv || char_check !== e_cc || (e_nv && nib_data !== e_nib)) begin
        errors++;
        $display("FAIL rand_pulse cyc=%0d got nv=%b cc=%b nib=%h required %b %b %h", cyc, nib_valid, char_check, nib_data, e_nv, e_cc, e_nib);
      end
      checks++;
      if (frame_done !== e_done || frame_len !== e_len || frame_err !== e_err || err_code !== e_code ||
          rx_drop !== e_drop || busy !== (mode != 0)) begin
        errors++;
        $display("FAIL rand_status cyc=%0d got done=%b len=%0d err=%b code=%0d drop=%b busy=%b required %b %0d %b %0d %b %b",
                 cyc, frame_done, frame_len, frame_err, err_code, rx_drop, busy, e_done, e_len, e_err, e_code, e_drop, mode != 0);
      end
    end
    rx_strobe = 1'b0;
    frame_ack = 1'b0;
  endtask

  initial begin
    clear_mon();
    tick(1);
    test_reset();
    test_frame();
    test_overflow();
    test_badchar();
    test_timeout();
    test_done_drop();
    test_rst_mid();
    test_back_to_back();
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
